range_stream_tx: RTL and testbench
==================================

Name: range_stream_tx

Overview:
- Transmitter side of the range-measurement stream protocol: buffers up to DEPTH samples, then plays them out as one session.
- Session sequence: go with first sample, remaining samples, finish, then capture of the receiver's returned range (max-min).
- Drives the 12-bit receiver input bus (data[9:0], go = bit 10, finish = bit 11) and reads the receiver's 10-bit range output.
- Optionally self-checks the returned range against an internally computed expected value.

Parameters:
- DATA_W, 10, sample and range width (unsigned).
- DEPTH, 16, sample buffer entries (power of 2, >= 2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write wr_data into the buffer when idle and not full.
- wr_data  input  DATA_W  sample to buffer.
- clr  input  1  empty the buffer (idle only).
- start  input  1  begin a session (idle, count >= 1).
- range_in  input  DATA_W  range value returned by the receiver.
- tx_data  output  DATA_W  sample bus to receiver.
- tx_go  output  1  session start strobe.
- tx_finish  output  1  session end strobe.
- busy  output  1  session in progress.
- full  output  1  buffer count == DEPTH.
- count  output  $clog2(DEPTH)+1  samples buffered.
- result_valid  output  1  one-cycle pulse: range_result updated.
- range_result  output  DATA_W  captured range_in.
- mismatch  output  1  captured range differs from expected (RANGE_CHECK_EN only, else 0).

Behaviour:
- Reset (async): all outputs 0, count 0, FSM IDLE, tx_data 0. Reset mid-session aborts immediately; the buffer is emptied.
- All tx_* outputs are registered.
- FSM states:
  - IDLE -> GO on start with count >= 1.
  - GO -> STREAM if N > 1, else FINISH.
  - STREAM -> FINISH after the sample at index N-1 is driven.
  - FINISH -> CAPTURE.
  - CAPTURE -> IDLE.
- Timing, for N = count:
  - Cycle after start accepted = C1: tx_go = 1, tx_data = buf[0].
  - Cycles C1+1 .. C1+N-1: tx_go = 0, tx_data = buf[i].
  - Cycle C1+N: tx_finish = 1, tx_go = 0, tx_data = buf[N-1] (repeated so the receiver's min/max are unaffected).
  - Edge ending C1+N+1: range_in latched into range_result.
  - result_valid = 1 during C1+N+2 only; busy falls in the same cycle.
- tx_go and tx_finish are never high in the same cycle. tx_finish is never asserted outside a session.
- Outside sessions tx_data holds the last driven value, because the receiver keeps tracking min/max on idle data. tx_go and tx_finish are 0.
- busy is high from C1 through C1+N+1.
- While busy: wr_en, clr and start are ignored.
- start with count == 0: ignored, no bus activity.
- wr_en when full: write dropped, count unchanged.
- clr and wr_en in the same cycle: clr wins.
- The buffer is retained after a session; a new start replays it. Buffer write order equals transmit order.
- Expected range = max(buf[0..N-1]) - min(buf[0..N-1]): unsigned, DATA_W bits, never negative, accumulated during transmit.

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined: running min/max registers compare against range_in at capture; mismatch is set and held until the next start or reset.
- Undefined: no min/max logic; mismatch tied to 0.

Decomposition:
- Package range_pkg: DATA_W default constant, FSM state enum (IDLE, GO, STREAM, FINISH, CAPTURE), bus bit-position constants (GO_BIT = 10, FINISH_BIT = 11).
- Sub-module range_sample_buf: DEPTH x DATA_W register array with write pointer, count, full, and an indexed read port. Top contains FSM, read index and optional checker.

Test Plan:
- Write 5, 20, 3; start:
  - C1: go = 1, data = 5. C1+1: data = 20. C1+2: data = 3. C1+3: finish = 1, data = 3.
  - Receiver model returns 17 -> range_result = 17, result_valid pulse at C1+5, mismatch = 0.
- Single sample 42: go at C1, finish at C1+1 (never together) -> range_result = 0.
- start with empty buffer -> busy stays 0, tx_go/tx_finish never assert. Also 17 writes with DEPTH = 16 -> count = 16, full = 1, 17th dropped.
- RANGE_CHECK_EN defined, samples 5, 20, 3, model forced to return 9 -> mismatch = 1. A replay with the correct 17 clears it.
- Reset asserted at C1+1 of a 4-sample session -> all outputs 0 next cycle, count = 0. A fresh write of 7 plus start runs a clean session with result 0.
- wr_en, clr and start pulsed while busy -> ignored; the replayed session matches the original.

Source files
------------

// File: rtl/range_pkg.sv
// Shared definitions for the range-measurement stream transmitter:
// default widths, the session FSM state encoding and the bit positions
// of the strobes on the 12-bit receiver input bus.
package range_pkg;

  // Default sample / range width and sample buffer depth
  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 16;

  // Receiver input bus layout: data[9:0], go at bit 10, finish at bit 11
  localparam int BUS_W      = 12;
  localparam int GO_BIT     = 10;
  localparam int FINISH_BIT = 11;

  // Session sequencing states
  typedef enum logic [2:0] {
    IDLE,
    GO,
    STREAM,
    FINISH,
    CAPTURE
  } state_t;

endpackage : range_pkg

// File: rtl/range_sample_buf.sv
// Sample buffer for range_stream_tx: DEPTH x DATA_W register array with a
// write pointer, occupancy count, full flag and an asynchronous indexed
// read port. Writes beyond DEPTH are dropped; clr wins over wr_en.
// Storage words are not reset; only pointer and count are, which is what
// "empty" means for this buffer.
module range_sample_buf #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clr,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_write;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_write = wr_en && !clr && !full;
  assign count    = count_reg;
  assign rd_data  = mem[rd_addr];

  // Pointer and occupancy: clr empties, an accepted write advances both
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (do_write) begin
      wr_ptr_reg <= wr_ptr_reg + IDX_W'(1);
      count_reg  <= count_reg + CNT_W'(1);
    end
  end

  // Sample storage, written in arrival order so replay order matches
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

endmodule : range_sample_buf

// File: rtl/range_stream_tx.sv
// Transmitter side of the range-measurement stream protocol.
// Buffers up to DEPTH samples while idle, then on start plays them out as
// one session: go with the first sample, the remaining samples, a finish
// beat repeating the last sample, then captures the receiver's returned
// range one cycle later.
// Optional build macro RANGE_CHECK_EN: tracks min/max of the transmitted
// samples and flags a mismatch when the returned range disagrees.
module range_stream_tx
  import range_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr,
  input  logic                     start,
  input  logic [DATA_W-1:0]        range_in,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_go,
  output logic                     tx_finish,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     result_valid,
  output logic [DATA_W-1:0]        range_result,
  output logic                     mismatch
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;     // buffer index currently on tx_data
  logic [IDX_W-1:0]   rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               idle;
  logic               start_ok;
  logic               last_beat;

  assign idle     = (state_reg == IDLE);
  assign start_ok = idle && start && (count != '0);
  // True when the sample at index N-1 is the one being driven
  assign last_beat = ({1'b0, idx_reg} == (count - CNT_W'(1)));

  // Read address: first sample when launching, otherwise the next one
  always_comb begin
    rd_addr = '0;
    if (!idle) begin
      rd_addr = idx_reg + IDX_W'(1);
    end
  end

  // The buffer only changes while idle, so count is stable during a session
  range_sample_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en && idle),
    .wr_data (wr_data),
    .clr     (clr && idle),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  // Session FSM with registered bus outputs; tx_data holds between sessions
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      tx_data      <= '0;
      tx_go        <= 1'b0;
      tx_finish    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      range_result <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg <= GO;
            idx_reg   <= '0;
            tx_data   <= rd_data;
            tx_go     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GO, STREAM: begin
          tx_go <= 1'b0;
          if (last_beat) begin
            // Last sample stays on the bus so min/max are unaffected
            state_reg <= FINISH;
            tx_finish <= 1'b1;
          end else begin
            state_reg <= STREAM;
            idx_reg   <= idx_reg + IDX_W'(1);
            tx_data   <= rd_data;
          end
        end
        FINISH: begin
          tx_finish <= 1'b0;
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          range_result <= range_in;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef RANGE_CHECK_EN
  logic [DATA_W-1:0] min_reg;
  logic [DATA_W-1:0] max_reg;
  logic              mismatch_reg;
  logic              load_next;

  // A new sample is placed on the bus in GO/STREAM unless already at N-1
  assign load_next = ((state_reg == GO) || (state_reg == STREAM)) && !last_beat;

  // Running min/max over transmitted samples, compared on capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_reg      <= '0;
      max_reg      <= '0;
      mismatch_reg <= 1'b0;
    end else if (start_ok) begin
      min_reg      <= rd_data;
      max_reg      <= rd_data;
      mismatch_reg <= 1'b0;
    end else if (load_next) begin
      if (rd_data < min_reg) begin
        min_reg <= rd_data;
      end
      if (rd_data > max_reg) begin
        max_reg <= rd_data;
      end
    end else if (state_reg == CAPTURE) begin
      mismatch_reg <= (range_in != (max_reg - min_reg));
    end
  end

  assign mismatch = mismatch_reg;
`else
  assign mismatch = 1'b0;
`endif

endmodule : range_stream_tx

// File: tb/tb_range_stream_tx.sv
// Scoreboard bench for range_stream_tx: stimulus pushes expected bus beats
// and results into queues, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_range_stream_tx;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
`ifdef RANGE_CHECK_EN
  localparam logic CHECK_ON = 1'b1;
`else
  localparam logic CHECK_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic              clr   = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [DATA_W-1:0] range_in = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_go;
  logic              tx_finish;
  logic              busy;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              result_valid;
  logic [DATA_W-1:0] range_result;
  logic              mismatch;

  range_stream_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr          (clr),
    .start        (start),
    .range_in     (range_in),
    .tx_data      (tx_data),
    .tx_go        (tx_go),
    .tx_finish    (tx_finish),
    .busy         (busy),
    .full         (full),
    .count        (count),
    .result_valid (result_valid),
    .range_result (range_result),
    .mismatch     (mismatch)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic              go;
    logic              fin;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] rng;
    logic              mm;
  } res_t;

  beat_t             beat_q[$];
  res_t              res_q[$];
  int                pass_cnt  = 0;
  int                total_cnt = 0;
  logic [DATA_W-1:0] smp [DEPTH];
  logic              prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every busy cycle is one bus beat, result_valid is one result
  always @(negedge clock) begin
    beat_t b;
    res_t  r;
    if (!reset) begin
      chk("go_finish_exclusive", 32'(tx_go & tx_finish), 0);
      if (busy) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_busy_beat", 32'(busy), 0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_go", 32'(tx_go), 32'(b.go));
          chk("beat_finish", 32'(tx_finish), 32'(b.fin));
          chk("beat_data", 32'(tx_data), 32'(b.data));
        end
      end else begin
        chk("idle_go", 32'(tx_go), 0);
        chk("idle_finish", 32'(tx_finish), 0);
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 32'(result_valid), 0);
        end else begin
          r = res_q.pop_front();
          $display("result: range_result=%0d mismatch=%0d", range_result, mismatch);
          chk("range_result", 32'(range_result), 32'(r.rng));
          chk("mismatch", 32'(mismatch), 32'(r.mm));
          chk("busy_falls_with_result", 32'({prev_busy, busy}), 32'(2'b10));
        end
      end
    end
    prev_busy = busy;
  end

  task automatic write_sample(input logic [DATA_W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic clear_buf();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  // One session over smp[0..n-1]; receiver returns rin
  task automatic run_session(input int n, input logic [DATA_W-1:0] rin,
                             input logic emm, input bit disturb);
    beat_t b;
    res_t  r;
    for (int i = 0; i < n; i++) begin
      b.go = (i == 0); b.fin = 1'b0; b.data = smp[i];
      beat_q.push_back(b);
    end
    b.go = 1'b0; b.fin = 1'b1; b.data = smp[n-1];
    beat_q.push_back(b);
    b.go = 1'b0; b.fin = 1'b0; b.data = smp[n-1];
    beat_q.push_back(b);
    r.rng = rin; r.mm = emm;
    res_q.push_back(r);
    $display("session: n=%0d range_in=%0d disturb=%0d", n, rin, disturb);
    range_in = rin;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < n + 4; k++) begin
      if (disturb) begin
        case (k)
          0: begin wr_en = 1'b1; wr_data = 10'd999; end
          1: begin wr_en = 1'b0; clr = 1'b1; end
          2: begin clr = 1'b0; start = 1'b1; end
          3: begin start = 1'b0; end
          default: ;
        endcase
      end
      @(negedge clock);
    end
    chk("beats_drained", beat_q.size(), 0);
    chk("results_drained", res_q.size(), 0);
    beat_q.delete();
    res_q.delete();
    chk("idle_data_hold", 32'(tx_data), 32'(smp[n-1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_go", 32'(tx_go), 0);
    chk("rst_tx_finish", 32'(tx_finish), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_range_result", 32'(range_result), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    reset = 1'b0;
    @(negedge clock);

    // start with empty buffer: no activity
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("empty_start_busy", 32'(busy), 0);
    chk("empty_start_count", 32'(count), 0);

    // 5, 20, 3 -> range 17
    write_sample(10'd5); write_sample(10'd20); write_sample(10'd3);
    chk("count_three", 32'(count), 3);
    chk("not_full_three", 32'(full), 0);
    smp[0] = 10'd5; smp[1] = 10'd20; smp[2] = 10'd3;
    run_session(3, 10'd17, 1'b0, 1'b0);

    // Inputs pulsed while busy are ignored; replay identical
    run_session(3, 10'd17, 1'b0, 1'b1);
    chk("count_after_busy_inputs", 32'(count), 3);

    // Receiver returns a wrong range
    run_session(3, 10'd9, CHECK_ON, 1'b0);
    repeat (3) @(negedge clock);
    chk("mismatch_held", 32'(mismatch), 32'(CHECK_ON));
    run_session(3, 10'd17, 1'b0, 1'b0);
    chk("mismatch_cleared", 32'(mismatch), 0);

    // clr wins over wr_en in the same cycle
    clr = 1'b1; wr_en = 1'b1; wr_data = 10'd55;
    @(negedge clock);
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_wins_count", 32'(count), 0);

    // Single sample 42 -> range 0
    write_sample(10'd42);
    smp[0] = 10'd42;
    run_session(1, 10'd0, 1'b0, 1'b0);

    // Fill to DEPTH, 17th write dropped; samples 0,3,..,45 -> range 45
    clear_buf();
    for (int i = 0; i < DEPTH; i++) begin
      smp[i] = DATA_W'(i * 3);
      write_sample(smp[i]);
    end
    write_sample(10'd1000);
    chk("full_count", 32'(count), 16);
    chk("full_flag", 32'(full), 1);
    run_session(DEPTH, 10'd45, 1'b0, 1'b0);

    // Reset at C1+1 of a 4-sample session
    clear_buf();
    write_sample(10'd1); write_sample(10'd2); write_sample(10'd3); write_sample(10'd4);
    b.go = 1'b1; b.fin = 1'b0; b.data = 10'd1;
    beat_q.push_back(b);
    range_in = 10'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_tx_go", 32'(tx_go), 0);
    chk("midrst_tx_finish", 32'(tx_finish), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_full", 32'(full), 0);
    chk("midrst_result_valid", 32'(result_valid), 0);
    chk("midrst_range_result", 32'(range_result), 0);
    chk("midrst_mismatch", 32'(mismatch), 0);
    chk("midrst_first_beat_seen", beat_q.size(), 0);
    beat_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Clean session after reset
    write_sample(10'd7);
    smp[0] = 10'd7;
    run_session(1, 10'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_range_stream_tx
